// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: shared opcodes, ALUOp, state and mux-select encodings
package multicycle_control_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef enum logic [2:0] {
        ALU_IL    = 3'b000,
        ALU_B     = 3'b001,
        ALU_R     = 3'b010,
        ALU_I     = 3'b011,
        ALU_LUI   = 3'b100,
        ALU_AUIPC = 3'b101
    } aluop_t;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R,
        EXEC_I, EXEC_U, ALUWB, BRANCH, JAL, JALR, TRAP
    } state_t;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_PC     = 2'b11;

    localparam logic PCSRC_ALU    = 1'b0;
    localparam logic PCSRC_ALUOUT = 1'b1;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_ALUOUT = 1'b1;

    // Opcode dispatch out of DECODE; FENCE is a no-op back to FETCH.
    function automatic state_t decode_next(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE: return MEMADR;
            OP_R:              return EXEC_R;
            OP_I:              return EXEC_I;
            OP_LUI, OP_AUIPC:  return EXEC_U;
            OP_BRANCH:         return BRANCH;
            OP_JAL:            return JAL;
            OP_JALR:           return JALR;
            OP_FENCE:          return FETCH;
            default:           return TRAP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: instruction fields, flags, memory handshake and control lines
interface multicycle_control_if;
    logic [6:0] i_Opcode;
    logic [2:0] i_Funct3;
    logic       i_Zero;
    logic       i_Lt;
    logic       i_Ltu;
    logic       i_MemReady;
    logic [2:0] o_ALUOp;
    logic [1:0] o_ALUSrcA;
    logic [1:0] o_ALUSrcB;
    logic [1:0] o_ResultSrc;
    logic       o_PCSrc;
    logic       o_PCWrite;
    logic       o_IRWrite;
    logic       o_RegWrite;
    logic       o_MemRead;
    logic       o_MemWrite;
    logic       o_AdrSrc;
    logic       o_Illegal;
    logic [3:0] o_State;

    modport master (
        input  i_Opcode, i_Funct3, i_Zero, i_Lt, i_Ltu, i_MemReady,
        output o_ALUOp, o_ALUSrcA, o_ALUSrcB, o_ResultSrc, o_PCSrc, o_PCWrite,
               o_IRWrite, o_RegWrite, o_MemRead, o_MemWrite, o_AdrSrc, o_Illegal, o_State
    );

    modport slave (
        output i_Opcode, i_Funct3, i_Zero, i_Lt, i_Ltu, i_MemReady,
        input  o_ALUOp, o_ALUSrcA, o_ALUSrcB, o_ResultSrc, o_PCSrc, o_PCWrite,
               o_IRWrite, o_RegWrite, o_MemRead, o_MemWrite, o_AdrSrc, o_Illegal, o_State
    );
endinterface

// File: rtl/multicycle_control_branch_resolve.sv
// branch_resolve: funct3 plus ALU flags to branch taken / invalid funct3
module branch_resolve (
    input  logic [2:0] i_Funct3,
    input  logic       i_Zero,
    input  logic       i_Lt,
    input  logic       i_Ltu,
    output logic       o_Taken,
    output logic       o_Invalid
);
    // bit0 inverts the base condition; bits 2:1 pick Zero, Lt or Ltu
    always_comb begin
        o_Invalid = i_Funct3[2:1] == 2'b01;
        o_Taken   = (i_Funct3[2] ? (i_Funct3[1] ? i_Ltu : i_Lt) : i_Zero) ^ i_Funct3[0];
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: fetch/decode/execute/memory/write-back sequencer for the RV32I core
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    multicycle_control_if.master bus
);
    state_t state_q, state_d;
    logic   taken, invalid;

    branch_resolve u_branch (
        .i_Funct3  (bus.i_Funct3),
        .i_Zero    (bus.i_Zero),
        .i_Lt      (bus.i_Lt),
        .i_Ltu     (bus.i_Ltu),
        .o_Taken   (taken),
        .o_Invalid (invalid)
    );

    // state register; reset abandons any outstanding memory request
    always_ff @(posedge i_Clk) begin
        if (i_Rst) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // next state: memory states wait for ready, TRAP holds until reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:                   state_d = bus.i_MemReady ? DECODE : FETCH;
            DECODE:                  state_d = decode_next(bus.i_Opcode);
            MEMADR:                  state_d = bus.i_Opcode == OP_LOAD ? MEMRD : MEMWR;
            MEMRD:                   state_d = bus.i_MemReady ? MEMWB : MEMRD;
            MEMWR:                   state_d = bus.i_MemReady ? FETCH : MEMWR;
            EXEC_R, EXEC_I, EXEC_U:  state_d = ALUWB;
            BRANCH:                  state_d = invalid ? TRAP : FETCH;
            MEMWB, ALUWB, JAL, JALR: state_d = FETCH;
            TRAP:                    state_d = TRAP;
            default:                 state_d = FETCH;
        endcase
    end

    // outputs: selects are Moore, strobes gated only by ready or branch outcome
    always_comb begin
        bus.o_ALUOp     = ALU_IL;
        bus.o_ALUSrcA   = SRCA_PC;
        bus.o_ALUSrcB   = SRCB_RS2;
        bus.o_ResultSrc = RES_ALUOUT;
        bus.o_PCSrc     = PCSRC_ALU;
        bus.o_PCWrite   = 1'b0;
        bus.o_IRWrite   = 1'b0;
        bus.o_RegWrite  = 1'b0;
        bus.o_MemRead   = 1'b0;
        bus.o_MemWrite  = 1'b0;
        bus.o_AdrSrc    = ADR_PC;
        bus.o_Illegal   = state_q == TRAP;
        bus.o_State     = state_q;
        case (state_q)
            FETCH: begin
                bus.o_MemRead = 1'b1;
                bus.o_ALUSrcB = SRCB_FOUR;
                bus.o_IRWrite = bus.i_MemReady;
                bus.o_PCWrite = bus.i_MemReady;
            end
            DECODE: begin
                bus.o_ALUSrcA = SRCA_OLDPC;
                bus.o_ALUSrcB = SRCB_IMM;
            end
            MEMADR: begin
                bus.o_ALUSrcA = SRCA_RS1;
                bus.o_ALUSrcB = SRCB_IMM;
            end
            MEMRD: begin
                bus.o_MemRead = 1'b1;
                bus.o_AdrSrc  = ADR_ALUOUT;
            end
            MEMWB: begin
                bus.o_RegWrite  = 1'b1;
                bus.o_ResultSrc = RES_MEM;
            end
            MEMWR: begin
                bus.o_MemWrite = 1'b1;
                bus.o_AdrSrc   = ADR_ALUOUT;
            end
            EXEC_R: begin
                bus.o_ALUOp   = ALU_R;
                bus.o_ALUSrcA = SRCA_RS1;
            end
            EXEC_I: begin
                bus.o_ALUOp   = ALU_I;
                bus.o_ALUSrcA = SRCA_RS1;
                bus.o_ALUSrcB = SRCB_IMM;
            end
            EXEC_U: begin
                bus.o_ALUOp   = bus.i_Opcode == OP_LUI ? ALU_LUI : ALU_AUIPC;
                bus.o_ALUSrcA = bus.i_Opcode == OP_LUI ? SRCA_PC : SRCA_OLDPC;
                bus.o_ALUSrcB = SRCB_IMM;
            end
            ALUWB: bus.o_RegWrite = 1'b1;
            BRANCH: begin
                bus.o_ALUOp   = ALU_B;
                bus.o_ALUSrcA = SRCA_RS1;
                bus.o_PCSrc   = PCSRC_ALUOUT;
                bus.o_PCWrite = taken & ~invalid;
            end
            JAL: begin
                bus.o_RegWrite  = 1'b1;
                bus.o_ResultSrc = RES_PC;
                bus.o_PCWrite   = 1'b1;
                bus.o_PCSrc     = PCSRC_ALUOUT;
            end
            JALR: begin
                bus.o_ALUSrcA   = SRCA_RS1;
                bus.o_ALUSrcB   = SRCB_IMM;
                bus.o_RegWrite  = 1'b1;
                bus.o_ResultSrc = RES_PC;
                bus.o_PCWrite   = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: per-cycle trace check of the control FSM against an instruction-level model
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic [2:0] op;
        logic [1:0] sa, sb, rs;
        logic       pcs, pcw, irw, rw, mr, mw, adr, ill;
    } obs_t;

    logic i_Clk = 1'b0;
    logic i_Rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    obs_t exp_q[$];
    logic rdy_q[$];

    multicycle_control_if bus();

    multicycle_control dut (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .bus   (bus)
    );

    always #5 i_Clk = ~i_Clk;

    function automatic obs_t obs();
        return {bus.o_State, bus.o_ALUOp, bus.o_ALUSrcA, bus.o_ALUSrcB, bus.o_ResultSrc,
                bus.o_PCSrc, bus.o_PCWrite, bus.o_IRWrite, bus.o_RegWrite,
                bus.o_MemRead, bus.o_MemWrite, bus.o_AdrSrc, bus.o_Illegal};
    endfunction

    function automatic obs_t mk(state_t s, logic [2:0] op, logic [1:0] sa, logic [1:0] sb,
                                logic [1:0] rs, logic pcs, logic pcw, logic irw, logic rw,
                                logic mr, logic mw, logic adr);
        return {s, op, sa, sb, rs, pcs, pcw, irw, rw, mr, mw, adr, s == TRAP};
    endfunction

    function automatic logic rnd();
        return logic'($urandom_range(0, 1));
    endfunction

    // Builds the expected cycle-by-cycle trace of one instruction from the spec's state actions.
    task automatic gen(input logic [6:0] op, input logic [2:0] f3, input int wf, input int wm,
                       input logic z, input logic lt, input logic ltu, input bit hold,
                       output bit trapped);
        logic t;
        bit   valid;
        trapped = 0;
        for (int k = 0; k < wf; k++) begin
            exp_q.push_back(mk(FETCH, 3'b000, 2'b00, 2'b10, 2'b00, 0, 0, 0, 0, 1, 0, 0));
            rdy_q.push_back(1'b0);
        end
        exp_q.push_back(mk(FETCH, 3'b000, 2'b00, 2'b10, 2'b00, 0, 1, 1, 0, 1, 0, 0));
        rdy_q.push_back(1'b1);
        exp_q.push_back(mk(DECODE, 3'b000, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        rdy_q.push_back(hold ? 1'b1 : rnd());
        case (op)
            7'b0000011, 7'b0100011: begin
                exp_q.push_back(mk(MEMADR, 3'b000, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0));
                rdy_q.push_back(hold ? 1'b1 : rnd());
                for (int k = 0; k <= wm; k++) begin
                    if (op == 7'b0000011)
                        exp_q.push_back(mk(MEMRD, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 1));
                    else
                        exp_q.push_back(mk(MEMWR, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1));
                    rdy_q.push_back(k == wm);
                end
                if (op == 7'b0000011) begin
                    exp_q.push_back(mk(MEMWB, 3'b000, 2'b00, 2'b00, 2'b01, 0, 0, 0, 1, 0, 0, 0));
                    rdy_q.push_back(hold ? 1'b1 : rnd());
                end
            end
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: begin
                case (op)
                    7'b0110011: exp_q.push_back(mk(EXEC_R, 3'b010, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
                    7'b0010011: exp_q.push_back(mk(EXEC_I, 3'b011, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0));
                    7'b0110111: exp_q.push_back(mk(EXEC_U, 3'b100, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0));
                    default:    exp_q.push_back(mk(EXEC_U, 3'b101, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0));
                endcase
                rdy_q.push_back(hold ? 1'b1 : rnd());
                exp_q.push_back(mk(ALUWB, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0));
                rdy_q.push_back(hold ? 1'b1 : rnd());
            end
            7'b1100011: begin
                valid = 1;
                t = 0;
                case (f3)
                    3'd0: t = z;
                    3'd1: t = !z;
                    3'd4: t = lt;
                    3'd5: t = !lt;
                    3'd6: t = ltu;
                    3'd7: t = !ltu;
                    default: valid = 0;
                endcase
                exp_q.push_back(mk(BRANCH, 3'b001, 2'b10, 2'b00, 2'b00, 1, t & valid, 0, 0, 0, 0, 0));
                rdy_q.push_back(hold ? 1'b1 : rnd());
                trapped = !valid;
            end
            7'b1101111: begin
                exp_q.push_back(mk(JAL, 3'b000, 2'b00, 2'b00, 2'b11, 1, 1, 0, 1, 0, 0, 0));
                rdy_q.push_back(hold ? 1'b1 : rnd());
            end
            7'b1100111: begin
                exp_q.push_back(mk(JALR, 3'b000, 2'b10, 2'b01, 2'b11, 0, 1, 0, 1, 0, 0, 0));
                rdy_q.push_back(hold ? 1'b1 : rnd());
            end
            7'b0001111: ;
            default: trapped = 1;
        endcase
        if (trapped)
            for (int k = 0; k < 3; k++) begin
                exp_q.push_back(mk(TRAP, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
                rdy_q.push_back(k[0]);
            end
    endtask

    // Plays up to n queued cycles: drive ready after the edge, compare on the falling edge.
    task automatic run_q(input string nm, input int n);
        obs_t e;
        int   k = 0;
        while (exp_q.size() > 0 && k < n) begin
            e = exp_q.pop_front();
            bus.i_MemReady = rdy_q.pop_front();
            @(negedge i_Clk);
            tests++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL %s cycle %0d: got %h expected %h (state got %0d expected %0d)",
                         nm, k, obs(), e, bus.o_State, e.st);
            end
            @(posedge i_Clk);
            #1;
            k++;
        end
        exp_q.delete();
        rdy_q.delete();
    endtask

    task automatic instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                         input int wf, input int wm, input logic z, input logic lt,
                         input logic ltu, input bit hold, input int n, output bit trapped);
        bus.i_Opcode = op;
        bus.i_Funct3 = f3;
        bus.i_Zero   = z;
        bus.i_Lt     = lt;
        bus.i_Ltu    = ltu;
        gen(op, f3, wf, wm, z, lt, ltu, hold, trapped);
        run_q(nm, n);
    endtask

    task automatic reset_check(input string nm);
        bus.i_MemReady = 1'b0;
        i_Rst = 1'b1;
        @(posedge i_Clk);
        #1;
        @(negedge i_Clk);
        tests++;
        if (obs() !== mk(FETCH, 3'b000, 2'b00, 2'b10, 2'b00, 0, 0, 0, 0, 1, 0, 0)) begin
            fails++;
            $display("FAIL %s: got %h expected FETCH with only MemRead (state %0d illegal %b)",
                     nm, obs(), bus.o_State, bus.o_Illegal);
        end
        i_Rst = 1'b0;
        @(posedge i_Clk);
        #1;
    endtask

    task automatic test_reset();
        bus.i_Opcode = 7'b0;
        bus.i_Funct3 = 3'b0;
        bus.i_Zero   = 1'b0;
        bus.i_Lt     = 1'b0;
        bus.i_Ltu    = 1'b0;
        reset_check("reset");
    endtask

    task automatic test_rtype();
        bit tr;
        instr("rtype", 7'b0110011, 3'b000, 0, 0, 0, 0, 0, 1, 99, tr);
    endtask

    task automatic test_load_wait();
        bit tr;
        instr("load_wait", 7'b0000011, 3'b010, 0, 2, 0, 0, 0, 0, 99, tr);
    endtask

    task automatic test_branch();
        bit tr;
        instr("bne_not_taken", 7'b1100011, 3'b001, 0, 0, 1, 0, 0, 0, 99, tr);
        instr("bne_taken", 7'b1100011, 3'b001, 1, 0, 0, 0, 0, 0, 99, tr);
    endtask

    task automatic test_jal();
        bit tr;
        instr("jal", 7'b1101111, 3'b000, 0, 0, 0, 0, 0, 0, 99, tr);
    endtask

    task automatic test_trap();
        bit tr;
        instr("trap", 7'b1111111, 3'b000, 0, 0, 0, 0, 0, 0, 99, tr);
        reset_check("trap_reset");
    endtask

    task automatic test_reset_mid_store();
        bit tr;
        instr("store_mid", 7'b0100011, 3'b010, 0, 3, 0, 0, 0, 0, 4, tr);
        reset_check("store_reset");
    endtask

    task automatic test_random();
        logic [6:0] ops [10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0110111,
                                 7'b0010111, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0001111};
        logic [6:0] op;
        bit         tr;
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 11) == 0 ? 7'($urandom) : ops[$urandom_range(0, 9)];
            instr("random", op, 3'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                  rnd(), rnd(), rnd(), 0, 99, tr);
            if (tr) reset_check("random_reset");
        end
    endtask

    initial begin
        bus.i_MemReady = 1'b0;
        test_reset();
        test_rtype();
        test_load_wait();
        test_branch();
        test_jal();
        test_trap();
        test_reset_mid_store();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
